// File: rtl/pipe_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_ctrl_pkg
// Description : Shared types and constants for the pipeline hazard controller.
// Revision    : 1.0 - initial release
// ============================================================================
package pipe_ctrl_pkg;

    // Controller operating modes: normal flow, load-use bubble window,
    // post-redirect IF/ID flush window.
    typedef enum logic [1:0] {
        RUN   = 2'd0,
        LU    = 2'd1,
        REDIR = 2'd2
    } state_t;

    // Width of the bubble/flush window down-counter (windows up to 15 cycles).
    localparam int WIN_W = 4;

    // Default datapath widths.
    localparam int PC_W_DEF  = 32;
    localparam int CNT_W_DEF = 32;

endpackage : pipe_ctrl_pkg
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// ============================================================================
// Module      : sat_counter
// Description : Up-counter that sticks at all-ones instead of wrapping.
// Revision    : 1.0 - initial release
// ============================================================================
module sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] c_max = '1;

    logic [CNT_W-1:0] r_count;

    // Count on each enabled edge until the maximum value is reached.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count <= '0;
        end else if (inc && (r_count != c_max)) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign count = r_count;

endmodule : sat_counter
`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipe_hazard_ctrl
// Description : Stall/flush sequencer for the front-end pipeline. Turns
//               load-use, redirect and MEM-busy events into PC and pipeline
//               register control, with multi-cycle bubble/flush windows.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int PC_W        = PC_W_DEF,
    parameter int LU_BUBBLES  = 1,
    parameter int REDIR_FLUSH = 1,
    parameter int CNT_W       = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ld_use_hz,
    input  logic             br_redirect,
    input  logic [PC_W-1:0]  br_target,
    input  logic             mem_busy,
    output logic             pc_we,
    output logic             pc_sel,
    output logic [PC_W-1:0]  redirect_pc,
    output logic             if_id_stall,
    output logic             if_id_flush,
    output logic             id_ex_stall,
    output logic             id_ex_flush,
    output logic             ex_mem_stall,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] redirect_cnt
);

    // Reject window lengths the 4-bit counter cannot represent.
    if ((LU_BUBBLES < 1) || (LU_BUBBLES > 15)) begin : g_bad_lu_bubbles
        $error("LU_BUBBLES must be in 1..15");
    end
    if ((REDIR_FLUSH < 1) || (REDIR_FLUSH > 15)) begin : g_bad_redir_flush
        $error("REDIR_FLUSH must be in 1..15");
    end

    // Counter preload leaves cnt = remaining cycles after the entry cycle.
    localparam logic [WIN_W-1:0] c_lu_init    = WIN_W'(LU_BUBBLES - 1);
    localparam logic [WIN_W-1:0] c_redir_init = WIN_W'(REDIR_FLUSH - 1);

    state_t           r_state;
    logic [WIN_W-1:0] r_cnt;

    logic w_accept_redir;
    logic w_lu_start;

    assign w_accept_redir = br_redirect && !mem_busy;
    assign w_lu_start     = !mem_busy && !br_redirect && ld_use_hz && (r_state == RUN);

    // Window sequencer: freeze holds everything, redirect preempts all windows.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= RUN;
            r_cnt   <= '0;
        end else if (mem_busy) begin
            r_state <= r_state;
            r_cnt   <= r_cnt;
        end else if (br_redirect) begin
            r_state <= (REDIR_FLUSH > 1) ? REDIR : RUN;
            r_cnt   <= c_redir_init;
        end else begin
            case (r_state)
                RUN: begin
                    if (w_lu_start && (LU_BUBBLES > 1)) begin
                        r_state <= LU;
                        r_cnt   <= c_lu_init;
                    end
                end
                LU, REDIR: begin
                    if (r_cnt <= WIN_W'(1)) begin
                        r_state <= RUN;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt - WIN_W'(1);
                    end
                end
                default: begin
                    r_state <= RUN;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    // Same-cycle control decode from current state and inputs.
    always_comb begin
        pc_we        = 1'b1;
        pc_sel       = 1'b0;
        redirect_pc  = '0;
        if_id_stall  = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_stall  = 1'b0;
        id_ex_flush  = 1'b0;
        ex_mem_stall = 1'b0;
        if (!rst) begin
            pc_we       = 1'b0;
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
        end else if (mem_busy) begin
            pc_we        = 1'b0;
            if_id_stall  = 1'b1;
            id_ex_stall  = 1'b1;
            ex_mem_stall = 1'b1;
        end else if (br_redirect) begin
            pc_sel      = 1'b1;
            redirect_pc = br_target;
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
        end else begin
            case (r_state)
                RUN: begin
                    if (ld_use_hz) begin
                        pc_we       = 1'b0;
                        if_id_stall = 1'b1;
                        id_ex_flush = 1'b1;
                    end
                end
                LU: begin
                    pc_we       = 1'b0;
                    if_id_stall = 1'b1;
                    id_ex_flush = 1'b1;
                end
                REDIR: begin
                    if_id_flush = 1'b1;
                end
                default: begin
                    pc_we = 1'b1;
                end
            endcase
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (!pc_we),
        .count (stall_cycles)
    );

    sat_counter #(.CNT_W(CNT_W)) u_redir_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (w_accept_redir),
        .count (redirect_cnt)
    );

endmodule : pipe_hazard_ctrl
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_hazard_ctrl
// Description : Self-checking bench for pipe_hazard_ctrl against a
//               window-count reference model; directed scenarios then random.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_hazard_ctrl;

    localparam int c_LU = 3;
    localparam int c_RF = 3;
    localparam int c_CW = 4;
    localparam int c_PW = 32;
    localparam int c_SAT = (1 << c_CW) - 1;

    // Control vector order: {pc_we, pc_sel, if_id_stall, if_id_flush,
    //                        id_ex_stall, id_ex_flush, ex_mem_stall}
    localparam logic [6:0] c_CTL_RESET  = 7'b0001010;
    localparam logic [6:0] c_CTL_FREEZE = 7'b0010101;
    localparam logic [6:0] c_CTL_REDIR  = 7'b1101010;
    localparam logic [6:0] c_CTL_RFLUSH = 7'b1001000;
    localparam logic [6:0] c_CTL_BUBBLE = 7'b0010010;
    localparam logic [6:0] c_CTL_RUN    = 7'b1000000;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            ld_use_hz = 1'b0;
    logic            br_redirect = 1'b0;
    logic [c_PW-1:0] br_target = '0;
    logic            mem_busy = 1'b0;
    logic            pc_we, pc_sel, if_id_stall, if_id_flush;
    logic            id_ex_stall, id_ex_flush, ex_mem_stall;
    logic [c_PW-1:0] redirect_pc;
    logic [c_CW-1:0] stall_cycles, redirect_cnt;

    int checks = 0;
    int errors = 0;

    // Reference model: outstanding window cycles and counter values.
    int m_lu_left    = 0;
    int m_redir_left = 0;
    int m_stall      = 0;
    int m_redc       = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(
        .PC_W        (c_PW),
        .LU_BUBBLES  (c_LU),
        .REDIR_FLUSH (c_RF),
        .CNT_W       (c_CW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .ld_use_hz    (ld_use_hz),
        .br_redirect  (br_redirect),
        .br_target    (br_target),
        .mem_busy     (mem_busy),
        .pc_we        (pc_we),
        .pc_sel       (pc_sel),
        .redirect_pc  (redirect_pc),
        .if_id_stall  (if_id_stall),
        .if_id_flush  (if_id_flush),
        .id_ex_stall  (id_ex_stall),
        .id_ex_flush  (id_ex_flush),
        .ex_mem_stall (ex_mem_stall),
        .stall_cycles (stall_cycles),
        .redirect_cnt (redirect_cnt)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    // One clock cycle: drive after the edge, compare mid-cycle, advance model.
    task automatic step(input logic r, input logic ld, input logic br,
                        input logic [c_PW-1:0] tgt, input logic mb);
        logic [6:0]      e_ctl;
        logic [c_PW-1:0] e_pc;
        logic [6:0]      a_ctl;
        @(posedge clk);
        #1;
        rst = r; ld_use_hz = ld; br_redirect = br; br_target = tgt; mem_busy = mb;
        if (!r) begin
            m_lu_left = 0; m_redir_left = 0; m_stall = 0; m_redc = 0;
        end
        #4;
        e_pc = '0;
        if (!r)                    e_ctl = c_CTL_RESET;
        else if (mb)               e_ctl = c_CTL_FREEZE;
        else if (br) begin         e_ctl = c_CTL_REDIR; e_pc = tgt; end
        else if (m_redir_left > 0) e_ctl = c_CTL_RFLUSH;
        else if (m_lu_left > 0)    e_ctl = c_CTL_BUBBLE;
        else if (ld)               e_ctl = c_CTL_BUBBLE;
        else                       e_ctl = c_CTL_RUN;
        a_ctl = {pc_we, pc_sel, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush, ex_mem_stall};
        check_val("ctl", {25'b0, a_ctl}, {25'b0, e_ctl});
        check_val("redirect_pc", redirect_pc, e_pc);
        check_val("stall_cycles", {28'b0, stall_cycles}, m_stall);
        check_val("redirect_cnt", {28'b0, redirect_cnt}, m_redc);
        // Effect of the coming edge.
        if (r) begin
            if (!e_ctl[6] && m_stall < c_SAT) m_stall++;
            if (!mb) begin
                if (br) begin
                    m_redir_left = c_RF - 1;
                    m_lu_left    = 0;
                    if (m_redc < c_SAT) m_redc++;
                end else if (m_redir_left > 0) begin
                    m_redir_left--;
                end else if (m_lu_left > 0) begin
                    m_lu_left--;
                end else if (ld) begin
                    m_lu_left = c_LU - 1;
                end
            end
        end
    endtask

    initial begin
        // Reset with all inputs high, then release with inputs low.
        step(1'b0, 1'b1, 1'b1, 32'hFFFF_FFFF, 1'b1);
        check_val("rst_pc_we", {31'b0, pc_we}, 32'd0);
        step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        check_val("rel_pc_we", {31'b0, pc_we}, 32'd1);

        // Load-use bubble frozen during its second cycle.
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        check_val("lu_freeze_stalls", {28'b0, stall_cycles}, 32'd7);

        // Redirect with a three-cycle IF/ID flush window.
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        step(1'b1, 1'b0, 1'b1, 32'h0000_2000, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        check_val("redir_cnt_one", {28'b0, redirect_cnt}, 32'd1);

        // Priority: redirect over load-use, then freeze over both.
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 32'h0000_4000, 1'b0);
        step(1'b1, 1'b1, 1'b1, 32'h0000_5000, 1'b1);
        step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        check_val("freeze_redir_cnt", {28'b0, redirect_cnt}, 32'd1);

        // Reset in the middle of a flush window; no residue after release.
        step(1'b1, 1'b0, 1'b1, 32'h0000_6000, 1'b0);
        step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        check_val("post_rst_run", {31'b0, pc_we}, 32'd1);

        // Saturation of the stall counter.
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        for (int i = 0; i < 20; i++) step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
        step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        check_val("stall_sat", {28'b0, stall_cycles}, 32'hF);

        // Randomized traffic with occasional resets.
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 39) != 0),
                 ($urandom_range(0, 2) == 0),
                 ($urandom_range(0, 5) == 0),
                 $urandom,
                 ($urandom_range(0, 4) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_pipe_hazard_ctrl
`default_nettype wire

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central stall/flush sequencer for the front-end pipeline.
- Converts the hazard and redirect events raised by the ID, EX and MEM stages into per-cycle control for the PC register, if_id_pr, id_ex_pr and ex_mem_pr: write enable, stall, flush and PC select.
- Enforces multi-cycle bubble and flush windows through a small FSM.
- Exposes saturating performance counters.

Parameters:
- PC_W, 32, PC/redirect target width
- LU_BUBBLES, 1, load-use bubble cycles inserted (legal 1..15)
- REDIR_FLUSH, 1, IF/ID flush cycles per redirect (legal 1..15)
- CNT_W, 32, performance counter width

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- ld_use_hz  in  1  load-use hazard detected in ID
- br_redirect  in  1  EX resolved taken or mispredicted branch, single-cycle pulse
- br_target  in  PC_W  redirect target, valid with br_redirect
- mem_busy  in  1  MEM stage cannot accept; level signal
- pc_we  out  1  PC register write enable
- pc_sel  out  1  1 = load redirect_pc, 0 = sequential
- redirect_pc  out  PC_W  target driven to PC mux
- if_id_stall  out  1  to if_id_pr stall
- if_id_flush  out  1  to if_id_pr flush
- id_ex_stall  out  1  hold ID/EX
- id_ex_flush  out  1  insert bubble in ID/EX
- ex_mem_stall  out  1  hold EX/MEM
- stall_cycles  out  CNT_W  cycles with pc_we=0 and rst high
- redirect_cnt  out  CNT_W  accepted redirects

Behaviour:
- Reset (rst=0, async):
  - FSM goes to RUN, bubble/flush counter to 0, both perf counters to 0.
  - Control outputs while rst=0: pc_we=0, pc_sel=0, all stalls=0, if_id_flush=1, id_ex_flush=1, redirect_pc=0.
  - Reset asserted mid-window aborts the window; there is no residual bubble after release.
- Control outputs are combinational from FSM state and the current inputs. Same-cycle response, zero latency.
- Counters and state update on posedge clk.
- Priority within any state: mem_busy > br_redirect > ld_use_hz.
- mem_busy=1 (any state):
  - pc_we=0; if_id_stall, id_ex_stall and ex_mem_stall all 1; all flushes 0; pc_sel=0.
  - FSM state and window counter hold; the event is frozen, not lost.
  - br_redirect and ld_use_hz are ignored that cycle. Requesters hold ld_use_hz. EX holds br_redirect while frozen, because the EX/MEM stall keeps EX contents.
- Accepted redirect (br_redirect=1, mem_busy=0, any state):
  - pc_we=1, pc_sel=1, redirect_pc=br_target.
  - if_id_flush=1, id_ex_flush=1, stalls 0.
  - redirect_cnt increments.
  - Next state: REDIR with cnt=REDIR_FLUSH-1 if REDIR_FLUSH>1, else RUN.
  - Aborts any LU window in progress.
- States:
  - RUN, no event: pc_we=1, everything else 0, redirect_pc=0.
    - ld_use_hz=1: pc_we=0, if_id_stall=1, id_ex_flush=1. Next state is LU with cnt=LU_BUBBLES-1 if LU_BUBBLES>1, else RUN.
  - LU: pc_we=0, if_id_stall=1, id_ex_flush=1.
    - cnt decrements each non-frozen cycle. Return to RUN when cnt reaches 1 and is consumed.
    - ld_use_hz is ignored while in LU.
  - REDIR: pc_we=1, pc_sel=0, if_id_flush=1, other outputs 0.
    - cnt decrements each non-frozen cycle; exits to RUN on the same rule as LU.
    - ld_use_hz is ignored. A new br_redirect restarts the window.
- Flush beats stall: the controller never drives if_id_stall and if_id_flush both 1, nor id_ex_stall and id_ex_flush both 1.
- Perf counters saturate at 2^CNT_W-1 and never wrap.
- stall_cycles counts every posedge with rst high and pc_we=0, whether from a freeze or an LU bubble.
- Illegal parameter values are a compile-time error.

Decomposition:
- Package pipe_ctrl_pkg:
  - state enum: RUN, LU, REDIR
  - window counter width constant WIN_W=4
  - default PC_W and CNT_W constants
- Sub-module sat_counter (CNT_W, inc, clk, rst): used twice, for the two perf counters.

Test Plan:
- Reset: rst=0 with all inputs 1 → pc_we=0, if_id_flush=1, id_ex_flush=1, stall_cycles=0. Release rst with inputs 0 → pc_we=1, all others 0 on the next cycle.
- Load-use, LU_BUBBLES=2: pulse ld_use_hz for one cycle in RUN → pc_we=0, if_id_stall=1 and id_ex_flush=1 for exactly 2 cycles, then RUN. stall_cycles=2.
- Redirect, REDIR_FLUSH=3: br_redirect=1 with br_target=32'h0000_2000 → that cycle pc_sel=1, redirect_pc=32'h2000, both flushes 1. The next 2 cycles have if_id_flush=1 and pc_we=1. redirect_cnt=1.
- Priority: ld_use_hz=1 and br_redirect=1 together → redirect wins, id_ex_flush=1, if_id_stall=0. Then repeat with mem_busy=1 added → pure freeze, redirect_cnt unchanged.
- Freeze mid-window: LU_BUBBLES=3, mem_busy high for 4 cycles during the 2nd bubble → LU resumes afterwards for the remaining 2 cycles. stall_cycles=7.
- Reset mid-REDIR and saturation: rst low during REDIR → outputs go to reset values immediately. With CNT_W=4 and 20 stall cycles → stall_cycles holds at 4'hF.
